// File: rtl/ram_responder.sv
// RAM responder for the CU bus with a byte-serial little-endian program loader.
// After the image is loaded the FSM parks in RUN and raises cpu_enable.
module ram_responder #(
    parameter int adlines   = 8,
    parameter int datalines = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [adlines-1:0]   addressbus,
    input  logic                 read,
    input  logic                 write,
    input  logic [datalines-1:0] toram,
    output logic [datalines-1:0] fromram,
    input  logic [7:0]           ld_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    output logic                 cpu_enable,
    output logic                 err
);

    // state  | meaning
    // HDR_LO | waiting for header low byte
    // HDR_HI | waiting for header high byte
    // DAT_LO | waiting for data word low byte
    // DAT_HI | waiting for data word high byte, write on accept
    // RUN    | load done, CU owns the RAM
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DAT_LO, DAT_HI, RUN} state_t;

    localparam logic [16:0] DEPTH = 17'(2 ** adlines);

    state_t                 state_q, state_d;
    logic [7:0]             lo_q, lo_d;
    logic [15:0]            n_q, n_d;
    logic [16:0]            cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   en_q;
    logic                   accept;
    logic                   we;
    logic [adlines-1:0]     waddr;
    logic [datalines-1:0]   wdata;
    logic [datalines-1:0]   mem_q [2 ** adlines];

    assign ld_ready   = (state_q != RUN);
    assign accept     = ld_valid & ld_ready;
    assign cpu_enable = en_q;
    assign err        = err_q;
    assign fromram    = (state_q == RUN && read) ? mem_q[addressbus] : '0;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we      = 1'b0;
        waddr   = addressbus;
        wdata   = toram;
        case (state_q)
            HDR_LO: if (accept) begin
                lo_d    = ld_data;
                state_d = HDR_HI;
            end
            HDR_HI: if (accept) begin
                n_d     = {ld_data, lo_q};
                cnt_d   = '0;
                state_d = ({ld_data, lo_q} == 16'd0) ? RUN : DAT_LO;
            end
            DAT_LO: if (accept) begin
                lo_d    = ld_data;
                state_d = DAT_HI;
            end
            DAT_HI: if (accept) begin
                // Words past the end of the RAM are dropped rather than wrapped.
                if (cnt_q < DEPTH) begin
                    we    = 1'b1;
                    waddr = cnt_q[adlines-1:0];
                    wdata = {ld_data, lo_q};
                end else begin
                    err_d = 1'b1;
                end
                cnt_d   = cnt_q + 17'd1;
                state_d = (cnt_q + 17'd1 == {1'b0, n_q}) ? RUN : DAT_LO;
            end
            RUN: begin
                if (write) begin
                    we    = 1'b1;
                    waddr = addressbus;
                    wdata = toram;
                end
                if (read && write) err_d = 1'b1;
            end
            default: state_d = HDR_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR_LO;
            lo_q    <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            en_q    <= (state_d == RUN);
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && !rst) mem_q[waddr] <= wdata;
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: loader images, RUN reads/writes, error cases.
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  addressbus = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] toram = '0;
    logic [15:0] fromram;
    logic [7:0]  ld_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic        cpu_enable;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] model [256];
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    ram_responder #(.adlines(8), .datalines(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .addressbus (addressbus),
        .read       (read),
        .write      (write),
        .toram      (toram),
        .fromram    (fromram),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .cpu_enable (cpu_enable),
        .err        (err)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_data  = b;
        ld_valid = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic cu_read(input string tag, input logic [7:0] a);
        logic [15:0] exp;
        addressbus = a;
        read = 1'b1;
        sb.push_back(model[a]);
        #1;
        exp = sb.pop_front();
        check(tag, fromram, exp);
        read = 1'b0;
    endtask

    task automatic cu_write(input logic [7:0] a, input logic [15:0] d);
        addressbus = a;
        toram = d;
        write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        model[a] = d;
    endtask

    initial begin
        do_reset();
        addressbus = 8'h00;
        read = 1'b1;
        #1;
        check("rst_fromram", fromram, 16'h0000);
        read = 1'b0;
        check("rst_ld_ready", {15'd0, ld_ready}, 16'd1);
        check("rst_cpu_enable", {15'd0, cpu_enable}, 16'd0);
        check("rst_err", {15'd0, err}, 16'd0);

        // empty image
        send_byte(8'h00);
        check("n0_en_early", {15'd0, cpu_enable}, 16'd0);
        send_byte(8'h00);
        check("n0_cpu_enable", {15'd0, cpu_enable}, 16'd1);
        check("n0_ld_ready", {15'd0, ld_ready}, 16'd0);

        // three-word image, back-to-back bytes
        do_reset();
        send_word(16'h0003);
        send_word(16'h1111); model[0] = 16'h1111;
        send_word(16'h2222); model[1] = 16'h2222;
        send_byte(8'h33);
        addressbus = 8'h00;
        read = 1'b1;
        #1;
        check("load_fromram_gated", fromram, 16'h0000);
        read = 1'b0;
        check("n3_en_early", {15'd0, cpu_enable}, 16'd0);
        send_byte(8'h33); model[2] = 16'h3333;
        check("n3_cpu_enable", {15'd0, cpu_enable}, 16'd1);
        check("n3_ld_ready", {15'd0, ld_ready}, 16'd0);
        cu_read("n3_rd0", 8'd0);
        cu_read("n3_rd1", 8'd1);
        cu_read("n3_rd2", 8'd2);
        check("n3_err", {15'd0, err}, 16'd0);

        // RUN write then read; read low gives zero
        cu_write(8'h10, 16'hBEEF);
        cu_read("run_rd10", 8'h10);
        addressbus = 8'h10;
        #1;
        check("run_noread", fromram, 16'h0000);
        send_byte(8'h55);
        cu_read("run_ldvalid_ignored", 8'h10);

        // oversize image: 258 words, last two dropped
        do_reset();
        send_word(16'h0102);
        for (int k = 0; k < 256; k++) begin
            send_word(16'(k));
            model[k] = 16'(k);
        end
        check("ovf_err_before", {15'd0, err}, 16'd0);
        send_word(16'hDEAD);
        check("ovf_err", {15'd0, err}, 16'd1);
        check("ovf_en_early", {15'd0, cpu_enable}, 16'd0);
        send_word(16'hDEAD);
        check("ovf_cpu_enable", {15'd0, cpu_enable}, 16'd1);
        cu_read("ovf_rd0", 8'd0);
        cu_read("ovf_rd1", 8'd1);
        cu_read("ovf_rd128", 8'd128);
        cu_read("ovf_rd255", 8'd255);

        // read and write together at addr 5
        do_reset();
        send_word(16'h0000);
        addressbus = 8'd5;
        toram = 16'hAAAA;
        read = 1'b1;
        write = 1'b1;
        sb.push_back(model[5]);
        #1;
        check("rw_prewrite", fromram, sb.pop_front());
        @(posedge clk); #1;
        write = 1'b0;
        read = 1'b0;
        model[5] = 16'hAAAA;
        check("rw_err", {15'd0, err}, 16'd1);
        cu_read("rw_postwrite", 8'd5);
        repeat (3) @(posedge clk);
        #1;
        check("rw_err_sticky", {15'd0, err}, 16'd1);

        // reset in the middle of a load
        do_reset();
        send_word(16'h0005);
        send_word(16'hA001); model[0] = 16'hA001;
        send_word(16'hA002); model[1] = 16'hA002;
        send_word(16'hA003); model[2] = 16'hA003;
        do_reset();
        check("mid_ld_ready", {15'd0, ld_ready}, 16'd1);
        check("mid_cpu_enable", {15'd0, cpu_enable}, 16'd0);
        send_word(16'h0001);
        send_byte(8'h77);
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h77); model[0] = 16'h7777;
        check("mid_cpu_enable2", {15'd0, cpu_enable}, 16'd1);
        cu_read("mid_rd0", 8'd0);
        cu_read("mid_rd1", 8'd1);
        cu_read("mid_rd2", 8'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
